// File: rtl/proc_pkg.sv
// Shared processor types and default widths for the fetch and decode blocks.
package proc_pkg;

  localparam int unsigned DEF_ADDR_W  = 16;
  localparam int unsigned DEF_DATA_W  = 16;
  localparam int unsigned DEF_PC_STEP = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DELIVER = 2'd2,
    ERR     = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: request/address out, ack/data back.
interface instr_fetch_unit_if
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_timeout_counter.sv
// Counts REQ cycles; flags the cycle whose edge would be the TIMEOUT-th.
module fetch_timeout_counter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturating increment while enabled; clear has priority.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The current cycle completes TIMEOUT REQ cycles without an ack.
  assign expired = enable && (cnt_q >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle fetch unit: owns the PC, reads instruction memory, strobes the IR.
module instr_fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = DEF_PC_STEP,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               branch_valid,
  input  logic [ADDR_W-1:0]  branch_target,
  instr_fetch_unit_if.master mem,
  output logic               ir_write,
  output logic [DATA_W-1:0]  ir_data,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               fetch_err
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_data_q, ir_data_d;
  logic              mem_req_q, mem_req_d;
  logic              ir_write_q, ir_write_d;
  logic              fetch_err_q, fetch_err_d;
  logic              br_pend_q, br_pend_d;
  logic [ADDR_W-1:0] br_tgt_q, br_tgt_d;
  logic              cnt_clear_c;
  logic              expired_c;
  logic [ADDR_W-1:0] tgt_c;
  logic              redirect_c;
  logic [ADDR_W-1:0] redir_tgt_c;

  // Targets are halfword aligned; a newer branch overrides a latched one.
  assign tgt_c       = branch_target & ~ADDR_W'(1);
  assign redirect_c  = br_pend_q | branch_valid;
  assign redir_tgt_c = branch_valid ? tgt_c : br_tgt_q;

  fetch_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cnt_clear_c),
    .enable  (state_q == REQ),
    .expired (expired_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a branch in IDLE swallows a coincident fetch_en.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!branch_valid && fetch_en) state_d = REQ;
      end
      REQ: begin
        if (mem.mem_ack)    state_d = redirect_c ? IDLE : DELIVER;
        else if (expired_c) state_d = ERR;
      end
      DELIVER: state_d = IDLE;
      ERR: begin
        if (branch_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath next values; strobes follow the next state.
  always_comb begin
    pc_d        = pc_q;
    ir_data_d   = ir_data_q;
    br_pend_d   = br_pend_q;
    br_tgt_d    = br_tgt_q;
    cnt_clear_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        br_pend_d = 1'b0;
        if (branch_valid) begin
          pc_d = tgt_c;
        end else if (fetch_en) begin
          cnt_clear_c = 1'b1;
        end
      end
      REQ: begin
        if (branch_valid) begin
          br_pend_d = 1'b1;
          br_tgt_d  = tgt_c;
        end
        if (mem.mem_ack) begin
          br_pend_d = 1'b0;
          if (redirect_c) pc_d = redir_tgt_c;
          else            ir_data_d = mem.mem_rdata;
        end else if (expired_c) begin
          br_pend_d = 1'b0;
        end
      end
      DELIVER: begin
        pc_d = branch_valid ? tgt_c : pc_q + ADDR_W'(PC_STEP);
      end
      ERR: begin
        if (branch_valid) pc_d = tgt_c;
      end
      default: ;
    endcase
    mem_req_d   = (state_d == REQ);
    ir_write_d  = (state_d == DELIVER);
    fetch_err_d = (state_d == ERR);
  end

  // Registered outputs and branch-pending latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      ir_data_q   <= '0;
      mem_req_q   <= 1'b0;
      ir_write_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      br_pend_q   <= 1'b0;
      br_tgt_q    <= '0;
    end else begin
      pc_q        <= pc_d;
      ir_data_q   <= ir_data_d;
      mem_req_q   <= mem_req_d;
      ir_write_q  <= ir_write_d;
      fetch_err_q <= fetch_err_d;
      br_pend_q   <= br_pend_d;
      br_tgt_q    <= br_tgt_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = pc_q;
  assign ir_write     = ir_write_q;
  assign ir_data      = ir_data_q;
  assign pc           = pc_q;
  assign fetch_err    = fetch_err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        branch_valid;
  logic [15:0] branch_target;
  logic        ir_write;
  logic [15:0] ir_data;
  logic [15:0] pc;
  logic        busy;
  logic        fetch_err;

  int n_vec;
  int n_err;
  int ir_pulses;

  instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) mem_if ();

  instr_fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (16'h0000),
    .PC_STEP  (2),
    .TIMEOUT  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .mem           (mem_if),
    .ir_write      (ir_write),
    .ir_data       (ir_data),
    .pc            (pc),
    .busy          (busy),
    .fetch_err     (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; count IR strobes seen.
  task automatic step();
    @(posedge clk);
    #1;
    if (ir_write === 1'b1) ir_pulses++;
  endtask

  task automatic apply_reset();
    fetch_en         = 1'b0;
    branch_valid     = 1'b0;
    branch_target    = 16'h0000;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    rst_n            = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ir_pulses = 0;
  endtask

  // One fetch with wait_cyc cycles before ack; checks handshake and delivery.
  task automatic do_fetch(input int wait_cyc, input logic [15:0] rdata,
                          input logic [15:0] exp_addr);
    logic [15:0] exp_pc;
    exp_pc = exp_addr + 16'd2;
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    n_vec++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== exp_addr) begin
      n_err++;
      $display("FAIL fetch_issue: req=%b addr=%h expected req=1 addr=%h",
               mem_if.mem_req, mem_if.mem_addr, exp_addr);
    end
    for (int w = 0; w < wait_cyc; w++) begin
      step();
      n_vec++;
      if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== exp_addr || ir_write !== 1'b0) begin
        n_err++;
        $display("FAIL fetch_wait%0d: req=%b addr=%h irw=%b expected req=1 addr=%h irw=0",
                 w, mem_if.mem_req, mem_if.mem_addr, ir_write, exp_addr);
      end
    end
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = rdata;
    step();
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    n_vec++;
    if (ir_write !== 1'b1 || ir_data !== rdata || mem_if.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_deliver: irw=%b data=%h req=%b expected irw=1 data=%h req=0",
               ir_write, ir_data, mem_if.mem_req, rdata);
    end
    step();
    n_vec++;
    if (ir_write !== 1'b0 || pc !== exp_pc || busy !== 1'b0 || ir_data !== rdata) begin
      n_err++;
      $display("FAIL fetch_done: irw=%b pc=%h busy=%b data=%h expected irw=0 pc=%h busy=0 data=%h",
               ir_write, pc, busy, ir_data, exp_pc, rdata);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 16'h0000 || pc !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_bus: req=%b addr=%h pc=%h expected 0/0000/0000",
               mem_if.mem_req, mem_if.mem_addr, pc);
    end
    n_vec++;
    if (ir_write !== 1'b0 || ir_data !== 16'h0000 || busy !== 1'b0 || fetch_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out: irw=%b data=%h busy=%b err=%b expected all 0",
               ir_write, ir_data, busy, fetch_err);
    end
  endtask

  task automatic test_single_fetch();
    apply_reset();
    do_fetch(0, 16'h1248, 16'h0000);
    n_vec++;
    if (ir_pulses !== 1) begin
      n_err++;
      $display("FAIL single_pulses: got %0d expected 1", ir_pulses);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_fetch(0, 16'hA001, 16'h0000);
    do_fetch(2, 16'hA002, 16'h0002);
    do_fetch(5, 16'hA003, 16'h0004);
    n_vec++;
    if (ir_pulses !== 3 || pc !== 16'h0006) begin
      n_err++;
      $display("FAIL b2b_total: pulses=%0d pc=%h expected 3 and 0006", ir_pulses, pc);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    branch_valid  = 1'b1;
    branch_target = 16'hFFFE;
    step();
    branch_valid = 1'b0;
    n_vec++;
    if (pc !== 16'hFFFE || busy !== 1'b0 || mem_if.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_preset: pc=%h busy=%b req=%b expected FFFE/0/0",
               pc, busy, mem_if.mem_req);
    end
    do_fetch(1, 16'hBEEF, 16'hFFFE);
    n_vec++;
    if (pc !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap_pc: got %h expected 0000", pc);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    do_fetch(0, 16'h1248, 16'h0000);
    ir_pulses = 0;
    // Branch while waiting for memory: ack is swallowed.
    fetch_en = 1'b1;
    step();
    fetch_en      = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 16'h0041;
    step();
    branch_valid = 1'b0;
    n_vec++;
    if (mem_if.mem_req !== 1'b1 || mem_if.mem_addr !== 16'h0002) begin
      n_err++;
      $display("FAIL br_req_held: req=%b addr=%h expected 1/0002",
               mem_if.mem_req, mem_if.mem_addr);
    end
    step();
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 16'hDEAD;
    step();
    mem_if.mem_ack = 1'b0;
    n_vec++;
    if (ir_write !== 1'b0 || ir_data !== 16'h1248 || pc !== 16'h0040 ||
        busy !== 1'b0 || mem_if.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL br_ack_drop: irw=%b data=%h pc=%h busy=%b req=%b expected 0/1248/0040/0/0",
               ir_write, ir_data, pc, busy, mem_if.mem_req);
    end
    step();
    // Two branches in one REQ: the later target wins.
    fetch_en = 1'b1;
    step();
    fetch_en      = 1'b0;
    branch_valid  = 1'b1;
    branch_target = 16'h0100;
    step();
    branch_target = 16'h0205;
    step();
    branch_valid     = 1'b0;
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 16'hCAFE;
    step();
    mem_if.mem_ack = 1'b0;
    n_vec++;
    if (pc !== 16'h0204 || ir_data !== 16'h1248 || ir_pulses !== 0) begin
      n_err++;
      $display("FAIL br_overwrite: pc=%h data=%h pulses=%0d expected 0204/1248/0",
               pc, ir_data, ir_pulses);
    end
    // Branch and fetch_en together in IDLE: no request.
    fetch_en      = 1'b1;
    branch_valid  = 1'b1;
    branch_target = 16'h0300;
    step();
    fetch_en     = 1'b0;
    branch_valid = 1'b0;
    n_vec++;
    if (mem_if.mem_req !== 1'b0 || busy !== 1'b0 || pc !== 16'h0300) begin
      n_err++;
      $display("FAIL br_idle_prio: req=%b busy=%b pc=%h expected 0/0/0300",
               mem_if.mem_req, busy, pc);
    end
    step();
    n_vec++;
    if (mem_if.mem_req !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL br_idle_noreq: req=%b busy=%b expected 0/0", mem_if.mem_req, busy);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      step();
      n_vec++;
      if (fetch_err !== 1'b0 || mem_if.mem_req !== 1'b1) begin
        n_err++;
        $display("FAIL tmo_early%0d: err=%b req=%b expected 0/1", i, fetch_err, mem_if.mem_req);
      end
    end
    step();
    n_vec++;
    if (fetch_err !== 1'b1 || mem_if.mem_req !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL tmo_edge16: err=%b req=%b busy=%b expected 1/0/1",
               fetch_err, mem_if.mem_req, busy);
    end
    fetch_en = 1'b1;
    repeat (3) step();
    fetch_en = 1'b0;
    n_vec++;
    if (fetch_err !== 1'b1 || mem_if.mem_req !== 1'b0 || pc !== 16'h0000) begin
      n_err++;
      $display("FAIL tmo_sticky: err=%b req=%b pc=%h expected 1/0/0000",
               fetch_err, mem_if.mem_req, pc);
    end
    branch_valid  = 1'b1;
    branch_target = 16'h0100;
    step();
    branch_valid = 1'b0;
    n_vec++;
    if (fetch_err !== 1'b0 || pc !== 16'h0100 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_recover: err=%b pc=%h busy=%b expected 0/0100/0", fetch_err, pc, busy);
    end
    do_fetch(0, 16'h5A5A, 16'h0100);
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_fetch(0, 16'hABCD, 16'h0000);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (mem_if.mem_req !== 1'b0 || mem_if.mem_addr !== 16'h0000 || pc !== 16'h0000 ||
        busy !== 1'b0) begin
      n_err++;
      $display("FAIL arst_bus: req=%b addr=%h pc=%h busy=%b expected 0/0000/0000/0",
               mem_if.mem_req, mem_if.mem_addr, pc, busy);
    end
    n_vec++;
    if (ir_write !== 1'b0 || ir_data !== 16'h0000 || fetch_err !== 1'b0) begin
      n_err++;
      $display("FAIL arst_out: irw=%b data=%h err=%b expected 0/0000/0",
               ir_write, ir_data, fetch_err);
    end
    @(negedge clk);
    rst_n            = 1'b1;
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 16'h7777;
    ir_pulses        = 0;
    step();
    step();
    mem_if.mem_ack = 1'b0;
    n_vec++;
    if (ir_pulses !== 0 || ir_data !== 16'h0000 || busy !== 1'b0 || pc !== 16'h0000 ||
        mem_if.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL arst_late_ack: pulses=%0d data=%h busy=%b pc=%h req=%b expected 0/0000/0/0000/0",
               ir_pulses, ir_data, busy, pc, mem_if.mem_req);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    ir_pulses = 0;
    rst_n            = 1'b0;
    fetch_en         = 1'b0;
    branch_valid     = 1'b0;
    branch_target    = 16'h0000;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_wrap();
    test_branch();
    test_timeout();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
